// File: rtl/aibcr3_txdig_pkg.sv
// Shared types and constants for the AIB TX serializer: FSM states, mode codes,
// PRBS7 seed/taps and the idle pad value.
package aibcr3_txdig_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_WARMUP = 2'b01,
    ST_ACTIVE = 2'b10,
    ST_DRAIN  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    MODE_SERIAL = 2'b00,
    MODE_ASYNC  = 2'b01,
    MODE_PRBS   = 2'b10,
    MODE_LPBK   = 2'b11
  } mode_e;

  localparam logic [6:0] PRBS_SEED   = 7'h7F;
  localparam int         PRBS_TAP_HI = 6;
  localparam int         PRBS_TAP_LO = 5;
  localparam logic       IDLE_DATA   = 1'b0;

  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
  endfunction

endpackage

// File: rtl/aibcr3_txdig_serch.sv
// One TX channel: RATIO-bit LSB-first shift register, loopback capture register
// and the pad output mux.
module aibcr3_txdig_serch
  import aibcr3_txdig_pkg::*;
#(
  parameter int RATIO = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_clr,
  input  logic [RATIO-1:0] i_word,
  input  mode_e            i_mode,
  input  logic             i_en,
  input  logic             i_run,
  input  logic             i_async,
  input  logic             i_prbs,
  input  logic             i_lpbk,
  output logic             o_tx
);

  logic [RATIO-1:0] r_sh;
  logic             r_lpbk;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh   <= '0;
      r_lpbk <= 1'b0;
    end else begin
      r_lpbk <= i_lpbk;
      if (i_clr)
        r_sh <= '0;
      else if (i_load)
        r_sh <= i_word;
      else if (i_shift)
        r_sh <= {1'b0, r_sh[RATIO-1:1]};
    end
  end

  // Async bypass follows the driver enable; PRBS/loopback only drive once running.
  always_comb begin
    o_tx = IDLE_DATA;
    if (i_en) begin
      case (i_mode)
        MODE_SERIAL: o_tx = r_sh[0];
        MODE_ASYNC:  o_tx = i_async;
        MODE_PRBS:   if (i_run) o_tx = i_prbs;
        MODE_LPBK:   if (i_run) o_tx = r_lpbk;
        default:     o_tx = IDLE_DATA;
      endcase
    end
  end

endmodule

// File: rtl/aibcr3_txdig_ser.sv
// AIB TX digital serializer: enable FSM with driver warm-up, shared bit counter,
// PRBS7 generator, underrun counter and weak-pull control; NCH channel slices.
module aibcr3_txdig_ser
  import aibcr3_txdig_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int RATIO = 4,
  parameter int WARM  = 8
) (
  input  logic                 ilaunch_clk,
  input  logic                 irst,
  input  logic [NCH*RATIO-1:0] idat,
  input  logic                 idat_vld,
  output logic                 idat_rdy,
  input  logic [1:0]           imode,
  input  logic [NCH-1:0]       async_data,
  input  logic [NCH-1:0]       ilpbk_dat,
  input  logic                 itx_en,
  input  logic                 rx_enb,
  input  logic                 test_weakpu,
  input  logic                 test_weakpd,
  output logic [NCH-1:0]       tx_dat_out,
  output logic                 itx_en_buf,
  output logic                 weak_pulldownen,
  output logic                 weak_pullupenb,
  output logic [7:0]           underrun_cnt
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

  state_e        r_state;
  mode_e         r_mode;
  logic [7:0]    r_wcnt;
  logic [CW-1:0] r_cnt;
  logic          r_loaded;
  logic [6:0]    r_lfsr;
  logic          r_prbs;
  logic [7:0]    r_urun;
  logic          r_rst_q;
  logic          r_wpd;
  logic          r_wpu_b;

  logic w_en_buf, w_run, w_serial, w_last, w_rdy, w_accept;
  logic w_underrun, w_shift, w_drain_done, w_ch_clr;

  assign w_en_buf     = (r_state != ST_OFF);
  assign w_run        = (r_state == ST_ACTIVE) || (r_state == ST_DRAIN);
  assign w_serial     = (r_mode == MODE_SERIAL);
  assign w_last       = (r_cnt == CW'(RATIO - 1));
  assign w_rdy        = (r_state == ST_ACTIVE) && w_serial && (!r_loaded || w_last);
  assign w_accept     = w_rdy && idat_vld;
  assign w_underrun   = (r_state == ST_ACTIVE) && w_serial && r_loaded && w_last && !idat_vld;
  assign w_shift      = w_run && w_serial && r_loaded && !w_last;
  assign w_drain_done = (r_state == ST_DRAIN) && (!w_serial || !r_loaded || w_last);
  // An underrun reloads the slices with an all-zero word so the gap lasts RATIO bits.
  assign w_ch_clr     = !w_run || w_underrun || w_drain_done;

  always_ff @(posedge ilaunch_clk) begin
    if (irst) begin
      r_state  <= ST_OFF;
      r_mode   <= MODE_SERIAL;
      r_wcnt   <= '0;
      r_cnt    <= '0;
      r_loaded <= 1'b0;
      r_lfsr   <= PRBS_SEED;
      r_prbs   <= IDLE_DATA;
      r_urun   <= '0;
      r_rst_q  <= 1'b1;
      r_wpd    <= 1'b1;
      r_wpu_b  <= 1'b1;
    end else begin
      r_rst_q <= 1'b0;
      r_wpd   <= test_weakpd | ~rx_enb | w_en_buf | r_rst_q;
      r_wpu_b <= ~test_weakpu | r_rst_q;
      r_prbs  <= IDLE_DATA;
      case (r_state)
        ST_OFF: begin
          r_cnt    <= '0;
          r_loaded <= 1'b0;
          if (itx_en) begin
            r_state <= ST_WARMUP;
            r_mode  <= mode_e'(imode);
            r_wcnt  <= '0;
          end
        end
        ST_WARMUP: begin
          if (!itx_en) begin
            r_state <= ST_OFF;
          end else if (r_wcnt == 8'(WARM - 1)) begin
            r_state <= ST_ACTIVE;
            r_lfsr  <= PRBS_SEED;
          end else begin
            r_wcnt <= r_wcnt + 8'd1;
          end
        end
        ST_ACTIVE: begin
          if (!itx_en)
            r_state <= ST_DRAIN;
          if (r_mode == MODE_PRBS) begin
            r_prbs <= r_lfsr[PRBS_TAP_HI];
            r_lfsr <= prbs7_next(r_lfsr);
          end
          if (w_accept) begin
            r_loaded <= 1'b1;
            r_cnt    <= '0;
          end else if (w_underrun) begin
            r_cnt <= '0;
            if (r_urun != 8'hFF)
              r_urun <= r_urun + 8'd1;
          end else if (w_shift) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DRAIN: begin
          if (w_drain_done) begin
            r_state  <= ST_OFF;
            r_loaded <= 1'b0;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= ST_OFF;
      endcase
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    aibcr3_txdig_serch #(.RATIO(RATIO)) u_ch (
      .i_clk   (ilaunch_clk),
      .i_rst   (irst),
      .i_load  (w_accept),
      .i_shift (w_shift),
      .i_clr   (w_ch_clr),
      .i_word  (idat[c*RATIO +: RATIO]),
      .i_mode  (r_mode),
      .i_en    (w_en_buf),
      .i_run   (w_run),
      .i_async (async_data[c]),
      .i_prbs  (r_prbs),
      .i_lpbk  (ilpbk_dat[c]),
      .o_tx    (tx_dat_out[c])
    );
  end

  assign idat_rdy        = w_rdy;
  assign itx_en_buf      = w_en_buf;
  assign weak_pulldownen = r_wpd;
  assign weak_pullupenb  = r_wpu_b;
  assign underrun_cnt    = r_urun;

endmodule

// File: tb/tb_aibcr3_txdig_ser.sv
// Directed bench for aibcr3_txdig_ser (NCH=4, RATIO=4, WARM=8): table-driven
// serial/drain/mode-lock vectors plus hand sequences for PRBS, bypass, reset and pulls.
module tb_aibcr3_txdig_ser;

  localparam int NCH   = 4;
  localparam int RATIO = 4;
  localparam int WARM  = 8;

  logic                 clk = 1'b0;
  logic                 irst;
  logic [NCH*RATIO-1:0] idat;
  logic                 idat_vld;
  logic                 idat_rdy;
  logic [1:0]           imode;
  logic [NCH-1:0]       async_data;
  logic [NCH-1:0]       ilpbk_dat;
  logic                 itx_en;
  logic                 rx_enb;
  logic                 test_weakpu;
  logic                 test_weakpd;
  logic [NCH-1:0]       tx_dat_out;
  logic                 itx_en_buf;
  logic                 weak_pulldownen;
  logic                 weak_pullupenb;
  logic [7:0]           underrun_cnt;

  always #5 clk = ~clk;

  aibcr3_txdig_ser #(.NCH(NCH), .RATIO(RATIO), .WARM(WARM)) dut (
    .ilaunch_clk     (clk),
    .irst            (irst),
    .idat            (idat),
    .idat_vld        (idat_vld),
    .idat_rdy        (idat_rdy),
    .imode           (imode),
    .async_data      (async_data),
    .ilpbk_dat       (ilpbk_dat),
    .itx_en          (itx_en),
    .rx_enb          (rx_enb),
    .test_weakpu     (test_weakpu),
    .test_weakpd     (test_weakpd),
    .tx_dat_out      (tx_dat_out),
    .itx_en_buf      (itx_en_buf),
    .weak_pulldownen (weak_pulldownen),
    .weak_pullupenb  (weak_pullupenb),
    .underrun_cnt    (underrun_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic        vld;
    logic [15:0] dat;
    logic [3:0]  exp_tx;
    logic        exp_rdy;
    logic        exp_buf;
    logic [7:0]  exp_urun;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit b of every channel's nibble, channel c in bit c.
  function automatic logic [3:0] wbits(input logic [15:0] w, input int b);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = w[c*4 + b];
    return r;
  endfunction

  task automatic add(input logic en, input logic [1:0] mode, input logic vld,
                     input logic [15:0] dat, input logic [3:0] tx, input logic rdy,
                     input logic eb, input logic [7:0] ur);
    vec_t v;
    v.en = en; v.mode = mode; v.vld = vld; v.dat = dat;
    v.exp_tx = tx; v.exp_rdy = rdy; v.exp_buf = eb; v.exp_urun = ur;
    vq.push_back(v);
  endtask

  task automatic run_table(input string tag);
    foreach (vq[i]) begin
      itx_en   = vq[i].en;
      imode    = vq[i].mode;
      idat_vld = vq[i].vld;
      idat     = vq[i].dat;
      tick();
      chk($sformatf("%s[%0d].tx", tag, i),   tx_dat_out,   vq[i].exp_tx);
      chk($sformatf("%s[%0d].rdy", tag, i),  idat_rdy,     vq[i].exp_rdy);
      chk($sformatf("%s[%0d].buf", tag, i),  itx_en_buf,   vq[i].exp_buf);
      chk($sformatf("%s[%0d].urun", tag, i), underrun_cnt, vq[i].exp_urun);
    end
    vq.delete();
  endtask

  task automatic do_reset();
    irst = 1'b1; itx_en = 1'b0; idat_vld = 1'b0; idat = '0; imode = 2'b00;
    tick(); tick();
    irst = 1'b0;
    tick(); tick();
  endtask

  task automatic warm_to_active(input logic [1:0] mode);
    itx_en = 1'b1; imode = mode;
    tick();
    repeat (WARM) tick();
  endtask

  logic [15:0] w0, w1, w2, w3, w4, w5;
  logic        bits[260];
  int          ones, mism;

  initial begin
    irst = 1'b1; idat = '0; idat_vld = 1'b0; imode = 2'b00; async_data = '0;
    ilpbk_dat = '0; itx_en = 1'b0; rx_enb = 1'b1; test_weakpu = 1'b0; test_weakpd = 1'b0;
    tick(); tick();
    chk("rst.tx",   tx_dat_out, 4'h0);
    chk("rst.buf",  itx_en_buf, 1'b0);
    chk("rst.rdy",  idat_rdy, 1'b0);
    chk("rst.urun", underrun_cnt, 8'd0);
    chk("rst.wpd",  weak_pulldownen, 1'b1);
    chk("rst.wpu",  weak_pullupenb, 1'b1);
    irst = 1'b0;
    tick();
    chk("rstq.wpd", weak_pulldownen, 1'b1);
    tick();
    chk("idle.wpd", weak_pulldownen, 1'b0);
    chk("idle.wpu", weak_pullupenb, 1'b1);

    test_weakpu = 1'b1; tick();
    chk("off.weakpu", weak_pullupenb, 1'b0);
    test_weakpu = 1'b0; rx_enb = 1'b0; tick();
    chk("rxen.wpd", weak_pulldownen, 1'b1);
    rx_enb = 1'b1; test_weakpd = 1'b1; tick();
    chk("weakpd.wpd", weak_pulldownen, 1'b1);
    test_weakpd = 1'b0; tick();
    chk("nopd.wpd", weak_pulldownen, 1'b0);

    // Serial: warm-up latency, back-to-back words, underrun gap, drain.
    w0 = 16'hA5C3; w1 = 16'h1234; w2 = 16'h0FF0; w3 = 16'h5A69; w4 = 16'hC3E1;
    for (int k = 0; k < 8; k++) add(1, 2'b00, 0, 16'h0, 4'h0, 0, 1, 0);
    add(1, 2'b00, 0, 16'h0, 4'h0, 1, 1, 0);
    add(1, 2'b00, 1, w0, 4'b0101, 0, 1, 0);
    add(1, 2'b00, 1, w1, 4'b1001, 0, 1, 0);
    add(1, 2'b00, 1, w1, 4'b0110, 0, 1, 0);
    add(1, 2'b00, 1, w1, 4'b1010, 1, 1, 0);
    add(1, 2'b00, 1, w1, wbits(w1, 0), 0, 1, 0);
    for (int b = 1; b < 4; b++) add(1, 2'b00, 1, w2, wbits(w1, b), b == 3, 1, 0);
    add(1, 2'b00, 1, w2, wbits(w2, 0), 0, 1, 0);
    for (int b = 1; b < 4; b++) add(1, 2'b00, 0, 16'h0, wbits(w2, b), b == 3, 1, 0);
    for (int b = 0; b < 4; b++) add(1, 2'b00, 0, 16'h0, 4'h0, b == 3, 1, 1);
    add(1, 2'b00, 1, w3, wbits(w3, 0), 0, 1, 1);
    for (int b = 1; b < 4; b++) add(1, 2'b00, 0, 16'h0, wbits(w3, b), b == 3, 1, 1);
    add(1, 2'b00, 1, w4, wbits(w4, 0), 0, 1, 1);
    add(1, 2'b00, 0, 16'h0, wbits(w4, 1), 0, 1, 1);
    add(0, 2'b00, 0, 16'h0, wbits(w4, 2), 0, 1, 1);
    add(0, 2'b00, 0, 16'h0, wbits(w4, 3), 0, 1, 1);
    add(0, 2'b00, 0, 16'h0, 4'h0, 0, 0, 1);
    add(0, 2'b00, 0, 16'h0, 4'h0, 0, 0, 1);
    run_table("ser");

    // Mode lock: imode moves to PRBS after the OFF->WARMUP latch.
    w5 = 16'h3C96;
    add(1, 2'b00, 0, 16'h0, 4'h0, 0, 1, 1);
    for (int k = 0; k < 7; k++) add(1, 2'b10, 0, 16'h0, 4'h0, 0, 1, 1);
    add(1, 2'b10, 0, 16'h0, 4'h0, 1, 1, 1);
    add(1, 2'b10, 1, w5, wbits(w5, 0), 0, 1, 1);
    for (int b = 1; b < 4; b++) add(0, 2'b10, 0, 16'h0, wbits(w5, b), 0, 1, 1);
    add(0, 2'b10, 0, 16'h0, 4'h0, 0, 0, 1);
    run_table("lock");

    // PRBS7 on all channels.
    warm_to_active(2'b10);
    imode = 2'b00;
    for (int k = 0; k < 260; k++) begin
      tick();
      bits[k] = tx_dat_out[0];
      if (k < 8 || k == 200)
        chk($sformatf("prbs.allch[%0d]", k), (tx_dat_out == 4'h0) || (tx_dat_out == 4'hF), 1'b1);
    end
    chk("prbs.rdy", idat_rdy, 1'b0);
    chk("prbs.first7", {bits[0], bits[1], bits[2], bits[3], bits[4], bits[5], bits[6]}, 7'h7F);
    chk("prbs.bit8", bits[7], 1'b0);
    ones = 0; mism = 0;
    for (int k = 0; k < 127; k++) begin
      if (bits[k]) ones++;
      if (bits[k] !== bits[k+127]) mism++;
    end
    chk("prbs.ones127", ones, 64);
    chk("prbs.period", mism, 0);
    itx_en = 1'b0; tick();
    chk("prbs.drain.buf", itx_en_buf, 1'b1);
    tick();
    chk("prbs.off.buf", itx_en_buf, 1'b0);
    chk("prbs.off.tx", tx_dat_out, 4'h0);

    // Loopback, one-cycle registered.
    warm_to_active(2'b11);
    ilpbk_dat = 4'h9; tick();
    chk("lpbk.a", tx_dat_out, 4'h9);
    ilpbk_dat = 4'h6; tick();
    chk("lpbk.b", tx_dat_out, 4'h6);
    ilpbk_dat = 4'h3; #1;
    chk("lpbk.reg", tx_dat_out, 4'h6);
    chk("lpbk.rdy", idat_rdy, 1'b0);
    itx_en = 1'b0; tick(); tick();
    chk("lpbk.off.tx", tx_dat_out, 4'h0);

    // Async bypass, combinational.
    warm_to_active(2'b01);
    async_data = 4'hB; #1;
    chk("async.a", tx_dat_out, 4'hB);
    chk("async.rdy", idat_rdy, 1'b0);
    async_data = 4'h4; #1;
    chk("async.b", tx_dat_out, 4'h4);
    itx_en = 1'b0; tick();
    chk("async.drain", tx_dat_out, 4'h4);
    tick();
    chk("async.off", tx_dat_out, 4'h0);
    async_data = 4'h0;

    // Reset in the middle of a word.
    warm_to_active(2'b00);
    test_weakpu = 1'b1;
    idat = 16'hFFFF; idat_vld = 1'b1; tick();
    idat_vld = 1'b0; tick(); tick();
    chk("midrst.bit2", tx_dat_out, 4'hF);
    chk("midrst.wpu.pre", weak_pullupenb, 1'b0);
    irst = 1'b1; tick();
    chk("midrst.tx", tx_dat_out, 4'h0);
    chk("midrst.buf", itx_en_buf, 1'b0);
    chk("midrst.wpd", weak_pulldownen, 1'b1);
    chk("midrst.wpu", weak_pullupenb, 1'b1);
    chk("midrst.urun", underrun_cnt, 8'd0);
    irst = 1'b0; itx_en = 1'b0; test_weakpu = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("midrst.after[%0d]", k), tx_dat_out, 4'h0);
    end

    // Underrun saturation.
    do_reset();
    warm_to_active(2'b00);
    idat = 16'h8421; idat_vld = 1'b1; tick();
    idat_vld = 1'b0;
    repeat (3) tick();
    chk("sat.pre", underrun_cnt, 8'd0);
    tick();
    chk("sat.first", underrun_cnt, 8'd1);
    repeat (1012) tick();
    chk("sat.254", underrun_cnt, 8'd254);
    repeat (4) tick();
    chk("sat.255", underrun_cnt, 8'd255);
    repeat (200) tick();
    chk("sat.hold", underrun_cnt, 8'd255);
    chk("sat.tx", tx_dat_out, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
